// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 line-read scheduler.
// One line is four 512-bit Avalon beats; credits are counted in lines.
package ddr3_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   localparam int BEATS_PER_LINE   = 4;
   localparam int DEF_CREDIT_LINES = 7;

endpackage

// File: rtl/ddr3_read_scheduler_if.sv
// Command, status and Avalon-MM read bundle for ddr3_read_scheduler.
// master = the scheduler side, slave = the controller/FIFO/command side.
interface ddr3_read_scheduler_if #(
   parameter int ADDR_W = 26,
   parameter int LEN_W  = 16
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  num_lines;
   logic              busy;
   logic              done;
   logic              err;
   logic              avl_read;
   logic [ADDR_W-1:0] avl_address;
   logic [2:0]        avl_burstcount;
   logic              avl_ready;
   logic              avl_rdata_valid;
   logic              line_consumed;

   modport master (
      input  start, base_addr, num_lines, avl_ready, avl_rdata_valid, line_consumed,
      output busy, done, err, avl_read, avl_address, avl_burstcount
   );

   modport slave (
      output start, base_addr, num_lines, avl_ready, avl_rdata_valid, line_consumed,
      input  busy, done, err, avl_read, avl_address, avl_burstcount
   );
endinterface

// File: rtl/line_credit_counter.sv
// Up/down line-credit counter: inc on request acceptance, dec on FIFO line pop.
// Simultaneous inc/dec holds the count; saturates at 0 and MAX_LINES, flags underflow.
module line_credit_counter #(
   parameter int MAX_LINES = 7,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic rstb,
   input  logic i_clr,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_available,
   output logic o_underflow
);
   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_LINES);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !i_dec && (r_count != LP_MAX)) begin
         r_count <= r_count + CNT_W'(1);
      end else if (i_dec && !i_inc && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_available = (r_count < LP_MAX);
   // A pop with nothing outstanding means the FIFO and this count disagree.
   assign o_underflow = i_dec & (r_count == '0);

endmodule

// File: rtl/ddr3_read_scheduler.sv
// Issues one 4-beat Avalon burst per 2048-bit line, throttled by line credits.
// avl_read is combinational from registered state (no issue bubble); held until avl_ready.
module ddr3_read_scheduler
   import ddr3_sched_pkg::*;
#(
   parameter int ADDR_W       = 26,
   parameter int LEN_W        = 16,
   parameter int CREDIT_LINES = DEF_CREDIT_LINES,
   parameter int CREDIT_W     = 3
) (
   input logic            clk,
   input logic            rstb,
   ddr3_read_scheduler_if.master bus
);
   localparam int BEAT_W = LEN_W + 2;

   sched_state_t      r_state;
   sched_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_num_lines;
   logic [LEN_W-1:0]  r_lines_issued;
   logic [LEN_W-1:0]  r_lines_consumed;
   logic [BEAT_W-1:0] r_beats_rcvd;
   logic              r_err;

   logic w_start;
   logic w_accept;
   logic w_final_accept;
   logic w_all_consumed;
   logic w_beat_err;
   logic w_credit_avail;
   logic w_credit_underflow;

   assign w_start        = (r_state == IDLE) & bus.start;
   assign w_accept       = bus.avl_read & bus.avl_ready;
   assign w_final_accept = w_accept & ((r_lines_issued + LEN_W'(1)) == r_num_lines);
   // Look ahead at this cycle's pop so done lands the cycle after the last consumption.
   assign w_all_consumed = (r_lines_consumed + LEN_W'(bus.line_consumed)) == r_num_lines;
   assign w_beat_err     = bus.avl_rdata_valid &
                           (r_beats_rcvd == BEAT_W'(r_lines_issued) * BEAT_W'(BEATS_PER_LINE));

   line_credit_counter #(
      .MAX_LINES (CREDIT_LINES),
      .CNT_W     (CREDIT_W)
   ) u_credit (
      .clk         (clk),
      .rstb        (rstb),
      .i_clr       (w_start),
      .i_inc       (w_accept),
      .i_dec       (bus.line_consumed),
      .o_available (w_credit_avail),
      .o_underflow (w_credit_underflow)
   );

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Credits only grow while a request waits, so avl_read cannot drop before acceptance.
   always_comb begin
      w_state_nxt  = r_state;
      bus.avl_read = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = (bus.num_lines == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            bus.busy     = 1'b1;
            bus.avl_read = (r_lines_issued < r_num_lines) & w_credit_avail;
            if (w_final_accept) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            bus.busy = 1'b1;
            if (w_all_consumed) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            bus.done    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_addr           <= '0;
         r_num_lines      <= '0;
         r_lines_issued   <= '0;
         r_lines_consumed <= '0;
         r_beats_rcvd     <= '0;
         r_err            <= 1'b0;
      end else begin
         if (w_start) begin
            r_addr           <= bus.base_addr;
            r_num_lines      <= bus.num_lines;
            r_lines_issued   <= '0;
            r_lines_consumed <= '0;
            r_beats_rcvd     <= '0;
         end else begin
            if (w_accept) begin
               r_lines_issued <= r_lines_issued + LEN_W'(1);
               r_addr         <= r_addr + ADDR_W'(BEATS_PER_LINE);
            end
            if (bus.line_consumed) begin
               r_lines_consumed <= r_lines_consumed + LEN_W'(1);
            end
            if (bus.avl_rdata_valid) begin
               r_beats_rcvd <= r_beats_rcvd + BEAT_W'(1);
            end
         end
         if (w_beat_err || w_credit_underflow) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.avl_address    = r_addr;
   assign bus.avl_burstcount = 3'(BEATS_PER_LINE);
   assign bus.err            = r_err;

endmodule

// File: tb/tb_ddr3_read_scheduler.sv
// Randomized bench for ddr3_read_scheduler: responder/consumer environment,
// scoreboard of expected burst addresses, line-level reference model.
module tb_ddr3_read_scheduler;
   localparam int ADDR_W  = 26;
   localparam int LEN_W   = 16;
   localparam int CREDITS = 7;

   logic clk  = 1'b0;
   logic rstb = 1'b0;

   ddr3_read_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   ddr3_read_scheduler #(
      .ADDR_W       (ADDR_W),
      .LEN_W        (LEN_W),
      .CREDIT_LINES (CREDITS),
      .CREDIT_W     (3)
   ) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Environment knobs (written by the main sequence)
   int ready_pct = 100;
   int cons_pct  = 100;
   int beat_pct  = 100;
   bit cons_en   = 1'b0;
   int bp_cycles = 0;
   int inj_beat_req = 0;
   int inj_cons_req = 0;

   // Monitor outputs
   bit mon_acc   = 1'b0;
   bit mon_rst   = 1'b0;
   bit mon_start = 1'b0;
   int acc_total  = 0;
   int done_total = 0;
   int stall_cnt  = 0;

   logic [ADDR_W-1:0] exp_addr_q[$];

   // Reference model state, line granularity
   bit m_active = 1'b0, m_busy = 1'b0, m_done_due = 1'b0, m_err = 1'b0;
   int m_n = 0, m_issued = 0, m_consumed = 0, m_out = 0, m_beats = 0;

   // Environment: memory responder (beats) and FIFO consumer (line pops)
   int env_pend = 0, env_fifo = 0, env_acc = 0, env_bp = 0;
   int env_beat_done = 0, env_cons_done = 0;

   initial begin
      bus.avl_ready       = 1'b0;
      bus.avl_rdata_valid = 1'b0;
      bus.line_consumed   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mon_rst) begin
            env_pend = 0;
            env_fifo = 0;
            env_acc  = 0;
         end else if (mon_acc) begin
            env_pend += 4;
            env_acc++;
         end
         if (mon_start) begin
            env_acc = 0;
            env_bp  = bp_cycles;
         end
         bus.line_consumed = 1'b0;
         if (env_cons_done != inj_cons_req) begin
            bus.line_consumed = 1'b1;
            env_cons_done++;
         end else if (cons_en && env_fifo >= 4 && $urandom_range(99) < cons_pct) begin
            bus.line_consumed = 1'b1;
            env_fifo -= 4;
         end
         bus.avl_rdata_valid = 1'b0;
         if (env_beat_done != inj_beat_req) begin
            bus.avl_rdata_valid = 1'b1;
            env_beat_done++;
         end else if (env_pend > 0 && $urandom_range(99) < beat_pct) begin
            bus.avl_rdata_valid = 1'b1;
            env_pend--;
            env_fifo++;
         end
         if (env_acc == 1 && env_bp > 0) begin
            bus.avl_ready = 1'b0;
            env_bp--;
         end else begin
            bus.avl_ready = ($urandom_range(99) < ready_pct);
         end
      end
   end

   // Monitor: compares against the model, pops the address scoreboard, then advances the model
   bit                acc, exp_rd, nd, cons;
   bit                prev_hold = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [ADDR_W-1:0] ea;

   initial begin
      forever begin
         @(negedge clk);
         acc    = bus.avl_read & bus.avl_ready;
         cons   = bus.line_consumed;
         exp_rd = m_active && (m_issued < m_n) && (m_out < CREDITS);
         chk("avl_read", bus.avl_read, exp_rd);
         chk("busy", bus.busy, m_busy);
         chk("done", bus.done, m_done_due);
         chk("err", bus.err, m_err);
         if (bus.avl_read) chk("burstcount", bus.avl_burstcount, 4);
         if (prev_hold) begin
            chk("hold_read", bus.avl_read, 1);
            chk("hold_addr", bus.avl_address, prev_addr);
         end
         if (acc) begin
            acc_total++;
            chk("req_expected", (exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) begin
               ea = exp_addr_q.pop_front();
               chk("req_addr", bus.avl_address, ea);
            end
         end
         if (bus.avl_read && !bus.avl_ready) stall_cnt++;
         if (bus.done) done_total++;
         prev_hold = rstb && bus.avl_read && !bus.avl_ready;
         prev_addr = bus.avl_address;
         mon_acc   = acc && rstb;
         mon_rst   = !rstb;
         mon_start = 1'b0;
         if (!rstb) begin
            m_active = 0; m_busy = 0; m_done_due = 0; m_err = 0;
            m_n = 0; m_issued = 0; m_consumed = 0; m_out = 0; m_beats = 0;
            exp_addr_q.delete();
         end else begin
            nd = 1'b0;
            if (bus.avl_rdata_valid) begin
               if (m_beats == 4 * m_issued) m_err = 1'b1;
               m_beats++;
            end
            if (cons) begin
               if (m_out == 0) m_err = 1'b1;
               m_consumed++;
               if (m_busy && m_consumed == m_n) begin
                  nd     = 1'b1;
                  m_busy = 1'b0;
               end
            end
            if (acc && !cons) m_out++;
            else if (!acc && cons && m_out > 0) m_out--;
            if (acc) m_issued++;
            if (bus.start && !m_busy && !m_done_due) begin
               m_n = int'(bus.num_lines);
               m_issued = 0; m_consumed = 0; m_out = 0; m_beats = 0;
               m_active  = 1'b1;
               mon_start = 1'b1;
               if (m_n == 0) nd = 1'b1;
               else m_busy = 1'b1;
            end
            m_done_due = nd;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input logic [ADDR_W-1:0] b, input int n, input bit expect_accept);
      bus.start     = 1'b1;
      bus.base_addr = b;
      bus.num_lines = LEN_W'(n);
      if (expect_accept)
         for (int i = 0; i < n; i++) exp_addr_q.push_back(b + ADDR_W'(4 * i));
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0;
      int c;
      d0 = done_total;
      c  = 0;
      while (done_total == d0 && c < budget) begin
         tick(1);
         c++;
      end
      chk(name, (done_total != d0), 1);
   endtask

   int a0, s0;
   logic [ADDR_W-1:0] rb;

   initial begin
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.num_lines = '0;
      rstb = 1'b0;
      tick(3);
      chk("rst_addr", bus.avl_address, 0);
      chk("rst_burst", bus.avl_burstcount, 4);
      rstb = 1'b1;
      tick(2);

      // Single line
      cons_en = 1'b1;
      a0 = acc_total;
      issue_start(26'h100, 1, 1'b1);
      wait_done("single_done", 200);
      chk("single_reqs", acc_total - a0, 1);

      // Credit stall, plus a start that must be ignored while busy
      cons_en = 1'b0;
      a0 = acc_total;
      issue_start(26'h0, 10, 1'b1);
      tick(40);
      chk("stall_reqs", acc_total - a0, 7);
      issue_start(26'h3000, 3, 1'b0);
      tick(5);
      chk("stall_still7", acc_total - a0, 7);
      cons_en = 1'b1;
      wait_done("stall_done", 500);
      chk("stall_total", acc_total - a0, 10);

      // Backpressure on the second request
      bp_cycles = 5;
      s0 = stall_cnt;
      issue_start(26'h0, 3, 1'b1);
      wait_done("bp_done", 300);
      chk("bp_stall_cycles", stall_cnt - s0, 5);
      bp_cycles = 0;

      // Zero-length command
      a0 = acc_total;
      issue_start(26'h40, 0, 1'b1);
      wait_done("zero_done", 10);
      chk("zero_reqs", acc_total - a0, 0);

      // Randomized runs, one straddling the address wrap
      for (int r = 0; r < 8; r++) begin
         ready_pct = $urandom_range(30, 100);
         cons_pct  = $urandom_range(20, 100);
         beat_pct  = $urandom_range(40, 100);
         rb = ADDR_W'($urandom);
         rb[1:0] = 2'b00;
         if (r == 3) rb = 26'h3FFFFF8;
         issue_start(rb, $urandom_range(1, 24), 1'b1);
         wait_done("rand_done", 3000);
      end
      ready_pct = 100;
      cons_pct  = 100;
      beat_pct  = 100;
      tick(2);

      // Errors: extra beat, sticky across a command, underflow after reset
      inj_beat_req++;
      tick(3);
      chk("err_extra_beat", bus.err, 1);
      issue_start(26'h80, 2, 1'b1);
      wait_done("err_run_done", 200);
      chk("err_sticky", bus.err, 1);
      rstb = 1'b0;
      tick(1);
      rstb = 1'b1;
      tick(1);
      chk("err_cleared", bus.err, 0);
      inj_cons_req++;
      tick(3);
      chk("err_underflow", bus.err, 1);
      rstb = 1'b0;
      tick(1);
      rstb = 1'b1;
      tick(1);

      // Reset in the middle of a run, then a clean command
      cons_en = 1'b0;
      a0 = acc_total;
      issue_start(26'h500, 8, 1'b1);
      for (int c = 0; c < 50 && (acc_total - a0) < 3; c++) tick(1);
      chk("mid_issued3", ((acc_total - a0) >= 3), 1);
      rstb = 1'b0;
      tick(1);
      chk("mid_rst_read", bus.avl_read, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_addr", bus.avl_address, 0);
      chk("mid_rst_err", bus.err, 0);
      rstb = 1'b1;
      tick(2);
      cons_en = 1'b1;
      a0 = acc_total;
      issue_start(26'h200, 2, 1'b1);
      wait_done("post_rst_done", 200);
      chk("post_rst_reqs", acc_total - a0, 2);
      chk("post_rst_err", bus.err, 0);
      tick(3);
      chk("queue_empty", exp_addr_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
